// File: rtl/pipe_mem_responder.sv
// Memory responder behind the pipeline's ready/valid memory ports.
// Fixed-latency reads return in order through a show-ahead queue; a credit count bounds outstanding reads.
module pipe_mem_responder #(
    parameter int ADDR_BITS  = 10,
    parameter int LATENCY    = 1,
    parameter int RESP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready_in,
    input  logic        valid_in,
    input  logic [31:0] addr_in,
    input  logic        op_in,
    input  logic [31:0] write_data_in,
    input  logic        ready_out,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic [3:0]  outstanding
);
    localparam int          WORDS   = 1 << ADDR_BITS;
    localparam int          PW      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [3:0]  DEPTH_C = 4'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

    logic [31:0]          mem [WORDS];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 live_q;
    logic                 accept, rd_accept, wr_accept, push, pop;
    logic [3:0]           out_cnt;

    logic [LATENCY:1]       vld_pipe;
    logic [LATENCY:1][31:0] dat_pipe;

    logic [RESP_DEPTH-1:0][31:0] q_mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [3:0]                  q_cnt;

    logic unused_addr;
    assign unused_addr = ^{addr_in[31:ADDR_BITS+2], addr_in[1:0]};

    assign word_idx  = addr_in[ADDR_BITS+1:2];
    // live_q keeps ready_in low until the first edge after reset release
    assign ready_in  = live_q && (out_cnt < DEPTH_C);
    assign accept    = valid_in && ready_in;
    assign rd_accept = accept && !op_in;
    assign wr_accept = accept && op_in;

    assign push      = vld_pipe[LATENCY];
    assign valid_out = (q_cnt != 4'd0);
    assign data_out  = valid_out ? q_mem[rd_ptr] : 32'd0;
    assign pop       = valid_out && ready_out;
    assign outstanding = out_cnt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[word_idx] <= write_data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            live_q <= 1'b0;
        else
            live_q <= 1'b1;
    end

    // Read data is captured at the accept edge, so the delay line only carries data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_accept;
            for (int i = 2; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dat_pipe[1] <= mem[word_idx];
        for (int i = 2; i <= LATENCY; i++)
            dat_pipe[i] <= dat_pipe[i-1];
    end

    // When full, push and pop target the same slot; the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= dat_pipe[LATENCY];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= 4'd0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 4'd1;
                2'b01:   q_cnt <= q_cnt - 4'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt <= 4'd0;
        end else begin
            case ({rd_accept, pop})
                2'b10:   out_cnt <= out_cnt + 4'd1;
                2'b01:   out_cnt <= out_cnt - 4'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Bench for pipe_mem_responder: two configurations share one stimulus stream,
// each checked every cycle against a queue-based behavioural model.
module tb_pipe_mem_responder;
    localparam int AB = 6;

    logic        clk = 1'b0, reset = 1'b0;
    logic        valid_in = 1'b0, op_in = 1'b0, ready_out = 1'b0;
    logic [31:0] addr_in = 32'd0, write_data_in = 32'd0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;
        localparam int D = (g == 0) ? 2 : 3;

        logic        ready_in, valid_out;
        logic [31:0] data_out;
        logic [3:0]  outstanding;

        pipe_mem_responder #(.ADDR_BITS(AB), .LATENCY(L), .RESP_DEPTH(D)) dut (
            .clk(clk), .reset(reset), .ready_in(ready_in), .valid_in(valid_in),
            .addr_in(addr_in), .op_in(op_in), .write_data_in(write_data_in),
            .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
            .outstanding(outstanding)
        );

        // Model: array memory, list of in-flight reads with due cycle, response queue.
        logic [31:0] m [1<<AB];
        logic [31:0] rq [$];
        int          fdue [$];
        logic [31:0] fdat [$];
        int          ocnt = 0, cyc = 0;
        bit          init = 0, acc, pp;
        logic [AB-1:0] ix;

        initial forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                rq.delete(); fdue.delete(); fdat.delete();
                ocnt = 0; init = 0;
            end else begin
                acc = valid_in && init && (ocnt < D);
                pp  = (rq.size() > 0) && ready_out;
                ix  = addr_in[AB+1:2];
                cyc++;
                if (pp) begin void'(rq.pop_front()); ocnt--; end
                while (fdue.size() > 0 && fdue[0] == cyc) begin
                    rq.push_back(fdat.pop_front());
                    void'(fdue.pop_front());
                end
                if (acc && op_in) m[ix] = write_data_in;
                else if (acc) begin
                    fdue.push_back(cyc + L);
                    fdat.push_back(m[ix]);
                    ocnt++;
                end
                init = 1;
            end
        end

        initial forever begin
            @(posedge clk);
            #1;
            chk($sformatf("i%0d ready_in", g), {31'd0, ready_in}, {31'd0, init && (ocnt < D)});
            chk($sformatf("i%0d valid_out", g), {31'd0, valid_out}, {31'd0, rq.size() > 0});
            chk($sformatf("i%0d data_out", g), data_out, (rq.size() > 0) ? rq[0] : 32'd0);
            chk($sformatf("i%0d outstanding", g), {28'd0, outstanding}, 32'(ocnt));
        end
    end

    task automatic chk_reset_state();
        chk("rst i0 ready_in", {31'd0, inst[0].ready_in}, 32'd0);
        chk("rst i0 valid_out", {31'd0, inst[0].valid_out}, 32'd0);
        chk("rst i0 data_out", inst[0].data_out, 32'd0);
        chk("rst i0 outstanding", {28'd0, inst[0].outstanding}, 32'd0);
        chk("rst i1 ready_in", {31'd0, inst[1].ready_in}, 32'd0);
        chk("rst i1 valid_out", {31'd0, inst[1].valid_out}, 32'd0);
        chk("rst i1 outstanding", {28'd0, inst[1].outstanding}, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a);
        valid_in = 1'b1; op_in = 1'b0; addr_in = a;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 chk_reset_state();
        step(); step();
        reset = 1'b0;
        step();
        chk("post-rst i0 ready_in", {31'd0, inst[0].ready_in}, 32'd1);
        chk("post-rst i1 ready_in", {31'd0, inst[1].ready_in}, 32'd1);

        // preload word i with (i+1)*0x11
        for (int i = 0; i < (1 << AB); i++) begin
            valid_in = 1'b1; op_in = 1'b1; addr_in = 32'(i * 4); write_data_in = 32'(i + 1) * 32'h11;
            step();
        end
        valid_in = 1'b0;

        // write then read through an unaligned alias of the same word
        ready_out = 1'b1;
        valid_in = 1'b1; op_in = 1'b1; addr_in = 32'h40; write_data_in = 32'hDEADBEEF;
        step();
        rd(32'h43);
        step();
        valid_in = 1'b0;
        chk("wr-rd i0 not yet", {31'd0, inst[0].valid_out}, 32'd0);
        step();
        chk("wr-rd i0 valid", {31'd0, inst[0].valid_out}, 32'd1);
        chk("wr-rd i0 data", inst[0].data_out, 32'hDEADBEEF);
        step();
        chk("wr-rd i1 not yet", {31'd0, inst[1].valid_out}, 32'd0);
        step();
        chk("wr-rd i1 valid", {31'd0, inst[1].valid_out}, 32'd1);
        chk("wr-rd i1 data", inst[1].data_out, 32'hDEADBEEF);
        step(); step();

        // backpressure: depth 2 on i0
        ready_out = 1'b0;
        rd(32'h0); step();
        rd(32'h4); step();
        chk("bp i0 ready_in low", {31'd0, inst[0].ready_in}, 32'd0);
        chk("bp i0 outstanding", {28'd0, inst[0].outstanding}, 32'd2);
        rd(32'h8); step();
        valid_in = 1'b0;
        chk("bp i0 3rd rejected", {28'd0, inst[0].outstanding}, 32'd2);
        step(); step(); step();
        chk("bp i0 head held", inst[0].data_out, 32'h11);
        ready_out = 1'b1;
        step();
        chk("bp i0 second", inst[0].data_out, 32'h22);
        chk("bp i0 ready back", {31'd0, inst[0].ready_in}, 32'd1);
        step();
        chk("bp i0 drained", {31'd0, inst[0].valid_out}, 32'd0);
        step();
        chk("bp i1 drained", {31'd0, inst[1].valid_out}, 32'd0);

        // accept and pop on the same edge
        ready_out = 1'b0;
        rd(32'h8); step();
        valid_in = 1'b0; step();
        chk("sim i0 pre out", {28'd0, inst[0].outstanding}, 32'd1);
        chk("sim i0 pre data", inst[0].data_out, 32'h33);
        rd(32'hC); ready_out = 1'b1; step();
        valid_in = 1'b0;
        chk("sim i0 out same", {28'd0, inst[0].outstanding}, 32'd1);
        step();
        chk("sim i0 new data", inst[0].data_out, 32'h44);
        repeat (6) step();

        // reset with a read in flight
        rd(32'h40); step();
        valid_in = 1'b0;
        #1 reset = 1'b1;
        #1 chk_reset_state();
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid-rst i0 no stale", {31'd0, inst[0].valid_out}, 32'd0);
            chk("mid-rst i1 no stale", {31'd0, inst[1].valid_out}, 32'd0);
        end
        rd(32'h40); step();
        valid_in = 1'b0; step();
        chk("mid-rst i0 kept", inst[0].data_out, 32'hDEADBEEF);
        step(); step();
        chk("mid-rst i1 kept", inst[1].data_out, 32'hDEADBEEF);
        step();

        // randomized traffic, full-width addresses exercise aliasing
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                #1 reset = 1'b1;
                #1 chk_reset_state();
                step();
                reset = 1'b0;
            end
            valid_in      = ($urandom_range(9) < 7);
            op_in         = ($urandom_range(9) < 3);
            addr_in       = $urandom;
            write_data_in = $urandom;
            ready_out     = ($urandom_range(9) < 6);
            step();
        end
        valid_in = 1'b0; ready_out = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
